// File: rtl/game_pkg.sv
// Shared definitions for the game datapath: state encoding, rule constants, defaults.
package game_pkg;

  localparam int         CELLS_DEF = 8;
  localparam logic [7:0] RULE_90   = 8'd90;
  localparam logic [7:0] RULE_30   = 8'd30;

  typedef enum logic [1:0] {
    DP_IDLE = 2'd0,
    DP_SCAN = 2'd1,
    DP_HOLD = 2'd2
  } dp_state_t;

endpackage

// File: rtl/board_datapath_if.sv
// Strobe interface between the game controller (master) and the board datapath (slave).
interface board_datapath_if #(
  parameter int CELLS = 8,
  parameter int GW    = 9
);
  logic             restart;
  logic             loadData;
  logic [CELLS-1:0] seed;
  logic             readData;
  logic             writeout;
  logic [CELLS-1:0] board;
  logic [GW-1:0]    gen;
  logic             scan_done;
  logic             loseSig;
  logic             proto_err;

  modport master (
    output restart, loadData, seed, readData, writeout,
    input  board, gen, scan_done, loseSig, proto_err
  );

  modport slave (
    input  restart, loadData, seed, readData, writeout,
    output board, gen, scan_done, loseSig, proto_err
  );
endinterface

// File: rtl/board_datapath_rule_lut.sv
// Elementary CA rule lookup: 3-bit {left,self,right} neighbourhood -> next cell value.
module rule_lut
  import game_pkg::*;
#(
  parameter logic [7:0] RULE = RULE_90
) (
  input  logic [2:0] nbr,
  output logic       next
);

  // Rule byte indexed directly by the neighbourhood pattern
  always_comb begin
    next = RULE[nbr];
  end

endmodule

// File: rtl/board_datapath.sv
// Responder datapath for the game controller: 1-D wrap-around CA board,
// evaluated one cell per readData into a shadow buffer, committed on writeout.
module board_datapath
  import game_pkg::*;
#(
  parameter int         CELLS = CELLS_DEF,
  parameter logic [7:0] RULE  = RULE_90,
  parameter int         GW    = 9
) (
  input  logic           clka,
  input  logic           rst_n,
  board_datapath_if.slave bus
);

  localparam int             IW   = (CELLS > 1) ? $clog2(CELLS) : 1;
  localparam logic [IW-1:0]  LAST = IW'(CELLS - 1);

  dp_state_t        state, state_nxt;
  logic [IW-1:0]    idx, idx_l, idx_r;
  logic [CELLS-1:0] work, shadow, board_q;
  logic [GW-1:0]    gen_q;
  logic             scan_done_q, lose_q, perr_q;
  logic             cell_nxt;
  logic             commit, scan_step, scan_last;

  // Neighbour indices with explicit wrap at both ends of the board
  always_comb begin
    idx_l = (idx == LAST) ? '0 : idx + 1'b1;
    idx_r = (idx == '0) ? LAST : idx - 1'b1;
  end

  rule_lut #(.RULE(RULE)) u_lut (
    .nbr  ({work[idx_l], work[idx], work[idx_r]}),
    .next (cell_nxt)
  );

  // Decode the one strobe that wins this cycle (restart > loadData > writeout > readData)
  always_comb begin
    commit    = !bus.restart && !bus.loadData && bus.writeout && (state == DP_HOLD);
    scan_step = !bus.restart && !bus.loadData && !bus.writeout && bus.readData &&
                (state == DP_SCAN);
    scan_last = scan_step && (idx == LAST);
  end

  // State register
  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) state <= DP_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (bus.restart)       state_nxt = DP_IDLE;
    else if (bus.loadData) state_nxt = DP_SCAN;
    else if (commit)       state_nxt = DP_SCAN;
    else if (scan_last)    state_nxt = DP_HOLD;
  end

  // Board registers, scan index, generation counter and sticky flags
  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      work        <= '0;
      shadow      <= '0;
      board_q     <= '0;
      gen_q       <= '0;
      idx         <= '0;
      scan_done_q <= 1'b0;
      lose_q      <= 1'b0;
      perr_q      <= 1'b0;
    end else if (bus.restart) begin
      work        <= '0;
      shadow      <= '0;
      board_q     <= '0;
      gen_q       <= '0;
      idx         <= '0;
      scan_done_q <= 1'b0;
      lose_q      <= 1'b0;
      perr_q      <= 1'b0;
    end else if (bus.loadData) begin
      work        <= bus.seed;
      idx         <= '0;
      scan_done_q <= 1'b0;
    end else if (bus.writeout) begin
      if (commit) begin
        work        <= shadow;
        board_q     <= shadow;
        if (gen_q != '1) gen_q <= gen_q + 1'b1;
        if (shadow == '0) lose_q <= 1'b1;
        scan_done_q <= 1'b0;
      end else begin
        perr_q <= 1'b1;
      end
    end else if (scan_step) begin
      shadow[idx] <= cell_nxt;
      idx         <= scan_last ? '0 : idx + 1'b1;
      if (scan_last) scan_done_q <= 1'b1;
    end
  end

  assign bus.board     = board_q;
  assign bus.gen       = gen_q;
  assign bus.scan_done = scan_done_q;
  assign bus.loseSig   = lose_q;
  assign bus.proto_err = perr_q;

endmodule
